// File: rtl/conv_mac_acc.sv
// Accumulates acc_len+1 MAC partial sums (FP16 block-float or INT16) into one result and queues
// it in a 2-entry valid/ready output buffer. Define CONV_MAC_ACC_SAT_EN for saturating sums.
module conv_mac_acc #(
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned SIM_DELAY = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic [1:0]       calfmt,
  input  logic [15:0]      acc_len,
  input  logic [7:0]       acc_in_exp,
  input  logic [39:0]      acc_in_frac,
  input  logic             acc_in_valid,
  output logic [7:0]       acc_out_exp,
  output logic [ACC_W-1:0] acc_out_frac,
  output logic             acc_out_valid,
  input  logic             acc_out_ready,
  output logic             acc_ovf,
  output logic             acc_busy
);

  localparam int unsigned InW = 40;

  // Register updates carry no modelled delay; the parameter only keeps the interface stable.
  logic unused_sim_delay;
  assign unused_sim_delay = ^SIM_DELAY;

  logic             in_beat;
  logic             is_fp;
  logic             first_term;
  logic             last_term;
  logic [15:0]      eff_len;
  logic [15:0]      term_cnt_q, term_cnt_d;
  logic [15:0]      len_q, len_d;

  logic [7:0]       acc_exp_q, acc_exp_d;
  logic [ACC_W-1:0] acc_frac_q, acc_frac_d;
  logic [ACC_W-1:0] in_frac_ext;

  logic             in_exp_ge;
  logic [7:0]       big_exp;
  logic [7:0]       exp_diff;
  logic [ACC_W-1:0] big_frac;
  logic [ACC_W-1:0] small_frac;
  logic [ACC_W-1:0] small_aligned;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic [ACC_W-1:0] sum_res;
  logic             add_en;
  logic             sat_hold;

  logic             push;
  logic             push_ok;
  logic             pop;
  logic             fifo_full;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_exp_q  [2];
  logic [ACC_W-1:0] mem_frac_q [2];
  logic             ovf_q, ovf_d;

  assign in_beat     = aclken & acc_in_valid;
  assign is_fp       = (calfmt == 2'b10);
  assign first_term  = (term_cnt_q == 16'd0);
  assign eff_len     = first_term ? acc_len : len_q;
  assign last_term   = (term_cnt_q == eff_len);
  assign in_frac_ext = {{(ACC_W-InW){acc_in_frac[InW-1]}}, acc_in_frac};

  // Term counter and group length
  always_comb begin
    term_cnt_d = term_cnt_q;
    len_d      = len_q;
    if (in_beat) begin
      term_cnt_d = last_term ? 16'd0 : term_cnt_q + 16'd1;
      if (first_term) begin
        len_d = acc_len;
      end
    end
  end

  // Exponent alignment: the operand with the smaller exponent is shifted toward the larger one
  assign in_exp_ge = (acc_in_exp >= acc_exp_q);

  always_comb begin
    if (in_exp_ge) begin
      big_exp    = acc_in_exp;
      exp_diff   = acc_in_exp - acc_exp_q;
      big_frac   = in_frac_ext;
      small_frac = acc_frac_q;
    end else begin
      big_exp    = acc_exp_q;
      exp_diff   = acc_exp_q - acc_in_exp;
      big_frac   = acc_frac_q;
      small_frac = in_frac_ext;
    end
    if (32'(exp_diff) >= ACC_W) begin
      small_aligned = {ACC_W{small_frac[ACC_W-1]}};
    end else begin
      small_aligned = $unsigned($signed(small_frac) >>> exp_diff);
    end
  end

  assign add_a   = is_fp ? big_frac : acc_frac_q;
  assign add_b   = is_fp ? small_aligned : in_frac_ext;
  assign add_sum = add_a + add_b;

  // A real add happens only when neither FP operand is zero; zero operands take the bypass paths
  assign add_en = in_beat & ~first_term & ~sat_hold &
                  (~is_fp | ((acc_in_frac != '0) & (acc_frac_q != '0)));

`ifdef CONV_MAC_ACC_SAT_EN
  logic sat_q, sat_d;
  logic add_ovf;

  always_comb begin
    add_ovf = (add_a[ACC_W-1] == add_b[ACC_W-1]) && (add_sum[ACC_W-1] != add_a[ACC_W-1]);
    sum_res = add_sum;
    if (add_ovf) begin
      sum_res = add_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    sat_d = sat_q;
    if (in_beat && first_term) begin
      sat_d = 1'b0;
    end else if (add_en && add_ovf) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_hold = sat_q;
`else
  assign sum_res  = add_sum;
  assign sat_hold = 1'b0;
`endif

  // Accumulator next state
  always_comb begin
    acc_exp_d  = acc_exp_q;
    acc_frac_d = acc_frac_q;
    if (in_beat && first_term) begin
      acc_exp_d  = is_fp ? acc_in_exp : 8'd0;
      acc_frac_d = in_frac_ext;
    end else if (add_en) begin
      acc_exp_d  = is_fp ? big_exp : 8'd0;
      acc_frac_d = sum_res;
    end else if (in_beat && !sat_hold && is_fp && (acc_in_frac != '0)) begin
      // Accumulator is zero: adopt the input exponent rather than aligning to a stale one
      acc_exp_d  = acc_in_exp;
      acc_frac_d = in_frac_ext;
    end
  end

  // Output buffer
  assign push      = in_beat & last_term;
  assign pop       = aclken & acc_out_valid & acc_out_ready;
  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign push_ok   = push & (~fifo_full | pop);

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    ovf_d    = ovf_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      term_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      acc_exp_q  <= 8'd0;
      acc_frac_q <= '0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      term_cnt_q <= term_cnt_d;
      len_q      <= len_d;
      acc_exp_q  <= acc_exp_d;
      acc_frac_q <= acc_frac_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        mem_exp_q[i]  <= 8'd0;
        mem_frac_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_exp_q[wr_ptr_q]  <= acc_exp_d;
      mem_frac_q[wr_ptr_q] <= acc_frac_d;
    end
  end

  assign acc_out_valid = (fifo_cnt_q != 2'd0);
  assign acc_out_exp   = mem_exp_q[rd_ptr_q];
  assign acc_out_frac  = mem_frac_q[rd_ptr_q];
  assign acc_ovf       = ovf_q;
  assign acc_busy      = (term_cnt_q != 16'd0);

endmodule

// File: tb/tb_conv_mac_acc.sv
// Randomized and directed bench for conv_mac_acc against a value-level reference model.
module tb_conv_mac_acc;

  localparam int unsigned AccW = 48;
  localparam longint AccMax = (longint'(1) <<< (AccW - 1)) - 1;
  localparam longint AccMin = -(longint'(1) <<< (AccW - 1));
`ifdef CONV_MAC_ACC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            aresetn = 1'b1;
  logic            aclken = 1'b1;
  logic [1:0]      calfmt = 2'b01;
  logic [15:0]     acc_len = '0;
  logic [7:0]      acc_in_exp = '0;
  logic [39:0]     acc_in_frac = '0;
  logic            acc_in_valid = 1'b0;
  logic [7:0]      acc_out_exp;
  logic [AccW-1:0] acc_out_frac;
  logic            acc_out_valid;
  logic            acc_out_ready = 1'b1;
  logic            acc_ovf;
  logic            acc_busy;

  conv_mac_acc #(
    .ACC_W     (AccW),
    .SIM_DELAY (1)
  ) u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .aclken        (aclken),
    .calfmt        (calfmt),
    .acc_len       (acc_len),
    .acc_in_exp    (acc_in_exp),
    .acc_in_frac   (acc_in_frac),
    .acc_in_valid  (acc_in_valid),
    .acc_out_exp   (acc_out_exp),
    .acc_out_frac  (acc_out_frac),
    .acc_out_valid (acc_out_valid),
    .acc_out_ready (acc_out_ready),
    .acc_ovf       (acc_ovf),
    .acc_busy      (acc_busy)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, expv, $time);
    end
  endtask

  // Reference model: value-level accumulation plus a 2-deep result queue
  typedef struct {
    logic [7:0] e;
    longint     f;
  } res_t;

  res_t       m_q[$];
  int         m_cnt = 0;
  int         m_len = 0;
  logic [7:0] m_exp = '0;
  longint     m_frac = 0;
  bit         m_sat = 1'b0;
  bit         m_ovf = 1'b0;

  task automatic model_add(input longint a, input longint b);
    longint s;
    logic [AccW-1:0] t;
    s = a + b;
    if (SatEn) begin
      if (s > AccMax) begin
        s = AccMax;
        m_sat = 1'b1;
      end else if (s < AccMin) begin
        s = AccMin;
        m_sat = 1'b1;
      end
    end else begin
      t = s[AccW-1:0];
      s = longint'($signed(t));
    end
    m_frac = s;
  endtask

  always @(posedge aclk or negedge aresetn) begin : model
    longint     x;
    longint     fb;
    longint     fs;
    int         d;
    bit         fp;
    bit         done;
    logic [7:0] eb;
    res_t       r;
    if (!aresetn) begin
      m_q.delete();
      m_cnt  = 0;
      m_len  = 0;
      m_exp  = '0;
      m_frac = 0;
      m_sat  = 1'b0;
      m_ovf  = 1'b0;
    end else if (aclken) begin
      done = 1'b0;
      if (acc_in_valid) begin
        x  = longint'($signed(acc_in_frac));
        fp = (calfmt == 2'b10);
        if (m_cnt == 0) begin
          m_len  = int'(acc_len);
          m_exp  = fp ? acc_in_exp : 8'd0;
          m_frac = x;
          m_sat  = 1'b0;
        end else if (!m_sat) begin
          if (!fp) begin
            m_exp = 8'd0;
            model_add(m_frac, x);
          end else if (x == 0) begin
            m_frac = m_frac;
          end else if (m_frac == 0) begin
            m_exp  = acc_in_exp;
            m_frac = x;
          end else begin
            if (acc_in_exp >= m_exp) begin
              eb = acc_in_exp;
              fb = x;
              fs = m_frac;
              d  = int'(acc_in_exp) - int'(m_exp);
            end else begin
              eb = m_exp;
              fb = m_frac;
              fs = x;
              d  = int'(m_exp) - int'(acc_in_exp);
            end
            if (d >= int'(AccW)) fs = (fs < 0) ? -1 : 0;
            else fs = fs >>> d;
            m_exp = eb;
            model_add(fb, fs);
          end
        end
        m_cnt++;
        if (m_cnt == m_len + 1) begin
          done  = 1'b1;
          m_cnt = 0;
        end
      end
      if (m_q.size() > 0 && acc_out_ready) void'(m_q.pop_front());
      if (done) begin
        if (m_q.size() < 2) begin
          r.e = m_exp;
          r.f = m_frac;
          m_q.push_back(r);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check_outputs();
    logic [AccW-1:0] ef;
    check("valid", acc_out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      ef = m_q[0].f[AccW-1:0];
      check("exp", acc_out_exp, m_q[0].e);
      check("frac", acc_out_frac, ef);
    end
    check("ovf", acc_ovf, m_ovf);
    check("busy", acc_busy, m_cnt != 0);
  endtask

  task automatic cycle();
    @(negedge aclk);
    check_outputs();
  endtask

  task automatic beat(input logic [1:0] fmt, input logic [15:0] len, input logic [7:0] e,
                      input longint f);
    calfmt       = fmt;
    acc_len      = len;
    acc_in_exp   = e;
    acc_in_frac  = f[39:0];
    acc_in_valid = 1'b1;
    cycle();
    acc_in_valid = 1'b0;
  endtask

  task automatic drain();
    acc_in_valid  = 1'b0;
    acc_out_ready = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    #2 aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_valid", acc_out_valid, 0);
    check("rst_frac", acc_out_frac, 0);
    check("rst_exp", acc_out_exp, 0);
    check("rst_ovf", acc_ovf, 0);
    check("rst_busy", acc_busy, 0);
    aresetn = 1'b1;
    cycle();

    // FP16 alignment: 100*2^10 + 400*2^8 = 200*2^10
    beat(2'b10, 16'd1, 8'd10, 100);
    check("t1_early", acc_out_valid, 0);
    beat(2'b10, 16'd1, 8'd8, 400);
    check("t1_valid", acc_out_valid, 1);
    check("t1_exp", acc_out_exp, 10);
    check("t1_frac", acc_out_frac, 200);
    drain();

    // INT16 back-to-back groups
    for (int g = 0; g < 2; g++) begin
      beat(2'b01, 16'd3, 8'd0, 5);
      beat(2'b01, 16'd3, 8'd0, -7);
      beat(2'b01, 16'd3, 8'd0, 100);
      beat(2'b01, 16'd3, 8'd0, -1);
      check("t2_valid", acc_out_valid, 1);
      check("t2_exp", acc_out_exp, 0);
      check("t2_frac", acc_out_frac, 97);
    end
    drain();

    // FP16 zero accumulator and far-smaller term
    beat(2'b10, 16'd2, 8'd4, 0);
    beat(2'b10, 16'd2, 8'd20, -3);
    beat(2'b10, 16'd2, 8'd0, 1);
    check("t3_exp", acc_out_exp, 20);
    check("t3_frac", acc_out_frac, 64'h0000_FFFF_FFFF_FFFD);
    drain();

    // Backpressure and drop
    acc_out_ready = 1'b0;
    beat(2'b01, 16'd0, 8'd0, 1);
    beat(2'b01, 16'd0, 8'd0, 2);
    beat(2'b01, 16'd0, 8'd0, 3);
    check("t4_ovf", acc_ovf, 1);
    check("t4_first", acc_out_frac, 1);
    acc_out_ready = 1'b1;
    cycle();
    check("t4_second", acc_out_frac, 2);
    cycle();
    check("t4_empty", acc_out_valid, 0);

    // Reset mid-group
    beat(2'b01, 16'd3, 8'd0, 10);
    beat(2'b01, 16'd3, 8'd0, 20);
    check("t5_busy", acc_busy, 1);
    aresetn = 1'b0;
    #1;
    check("t5_rst_busy", acc_busy, 0);
    check("t5_rst_ovf", acc_ovf, 0);
    check("t5_rst_valid", acc_out_valid, 0);
    check("t5_rst_frac", acc_out_frac, 0);
    cycle();
    aresetn = 1'b1;
    for (int i = 1; i <= 4; i++) beat(2'b01, 16'd3, 8'd0, longint'(i));
    check("t5_frac", acc_out_frac, 10);
    drain();

    // Long INT16 group overflowing ACC_W
    for (int i = 0; i < 512; i++) beat(2'b01, 16'd511, 8'd0, (longint'(1) <<< 39) - 1);
    check("t6_frac", acc_out_frac, SatEn ? 64'h0000_7FFF_FFFF_FFFF : 64'h0000_FFFF_FFFF_FE00);
    drain();

    // Random traffic with clock-enable gaps, backpressure and mid-group length changes
    for (int n = 0; n < 4000; n++) begin
      logic [63:0] r;
      int          v;
      aclken        = ($urandom_range(0, 9) != 0);
      acc_out_ready = ($urandom_range(0, 3) != 0);
      acc_len       = 16'($urandom_range(0, 4));
      if (m_cnt == 0) calfmt = 2'($urandom_range(0, 2));
      acc_in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) acc_in_exp = 8'($urandom_range(0, 255));
      else acc_in_exp = 8'($urandom_range(0, 20));
      if (calfmt == 2'b10) begin
        v = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
        acc_in_frac = ($urandom_range(0, 5) == 0) ? 40'd0 : 40'(v);
      end else begin
        r = {$urandom, $urandom};
        acc_in_frac = r[39:0];
      end
      cycle();
    end
    aclken = 1'b1;
    drain();
    check("end_empty", acc_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
